line_packer: RTL and testbench
==============================

Name: line_packer

Overview:
- Upstream feeder for the 5x5 bit-plane datapath.
- Accepts a stream of 5-bit rows over a valid/ready handshake and assembles each group of five rows into one 25-bit line.
- Presents each completed line to the datapath controller, which drives the line into MemoryBlock via initLine.
- Double-buffered: the next line is assembled while the current line waits for the controller to consume it.

Parameters:
ROW_W, 5, bits per input beat (one row of the plane)
ROWS, 5, beats per line
LINE_W, 25, line width; must equal ROW_W*ROWS
CNT_W, 8, width of the completed-line counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_row  input  ROW_W  row data; bit j of row i maps to line bit 5*i+j (same index as memIdx = 5i+j)
in_valid  input  1  in_row is valid this cycle
in_ready  output  1  packer can accept a row this cycle
flush  input  1  synchronous; discards the partially assembled line
line  output  LINE_W  completed line to the datapath
line_valid  output  1  line holds an unconsumed completed line
line_ack  input  1  controller consumes line (sampled only when line_valid=1)
row_idx  output  3  index of the next row to be written (0..ROWS-1)
line_count  output  CNT_W  lines delivered (acked), wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear; line=0, line_valid=0, row_idx=0, line_count=0.
  - Assembly state = FILL; in_ready=1 as soon as rst deasserts.
  - Reset mid-line discards partial data and any pending line.
- Storage:
  - Assembly register A (LINE_W bits), row counter r.
  - Output register O with flag line_valid.
- Row beat: accepted when in_valid & in_ready at a rising edge. It writes A[5r+4:5r] = in_row, then r <= r+1.
- Assembly FSM:
  - FILL: in_ready=1.
    - Beat with r<ROWS-1: write the row, increment r.
    - Beat with r=ROWS-1: completed value C = {in_row, A[19:0]}; r <= 0.
      - If O is free this cycle (line_valid=0, or line_ack=1 the same cycle), O <= C and line_valid=1 next cycle; stay in FILL.
      - Otherwise A <= C and go to HOLD.
  - HOLD: in_ready=0 (input stalls).
    - When O becomes free (line_valid=0, or line_ack=1), O <= A, line_valid stays/becomes 1, go to FILL.
    - The transfer coincides with the ack edge, so there are no bubble cycles.
- Output handshake:
  - line is stable while line_valid=1 and line_ack=0.
  - Ack with line_valid=1: line_count increments. If no transfer occurs the same edge, line_valid <= 0.
  - line_ack while line_valid=0 is ignored (no count).
- Latency: the last row accepted at edge N gives line_valid=1 from edge N (visible at cycle N+1) when O is free.
- Throughput: one row per cycle is sustained, provided the controller acks at least once per ROWS cycles.
- flush=1:
  - In FILL: r <= 0 and A <= 0; an in-row beat that same cycle is dropped (flush wins); O and line_valid are untouched.
  - In HOLD: flush is ignored, because the held line is complete.
- line_count wraps 255 -> 0 with no flag.
- Widths: row_idx is zero-extended from r; no arithmetic overflow is possible elsewhere.

Test Plan:
- Five beats 5'h01, 5'h02, 5'h04, 5'h08, 5'h10 with ack held 0 -> line = 25'h1041041 (bits 0, 6, 12, 18, 24 set), line_valid=1 the cycle after the fifth beat, row_idx back to 0.
- 15 back-to-back beats with no ack:
  - Line1 sits in O; line2 completes into A, FSM=HOLD, in_ready=0 from the cycle after the 10th beat; beats 11-15 stall.
  - One ack -> line = line2 on the next cycle, in_ready=1, line_count=1.
- Ack on the same edge as the 5th beat of line2 while line1 is valid -> line switches directly to line2, line_valid stays 1, no HOLD entry, line_count=1.
- Three beats then flush=1 with in_valid=1 -> row_idx=0, flushed beat dropped. The next five beats of 5'h1F give line = 25'h1FFFFFF.
- rst pulsed low mid-line with line_valid=1 -> line_valid=0, line=0, line_count=0 immediately (asynchronous), in_ready=1 after release.
- 256 complete lines, each acked -> line_count wraps to 0; line_ack while line_valid=0 leaves the count unchanged.

Source files
------------

// File: rtl/line_packer.sv
// Assembles groups of ROWS narrow row beats into one LINE_W-bit line, with a
// holding register so the next line can be built while the current one waits.
module line_packer #(
  parameter int ROW_W  = 5,
  parameter int ROWS   = 5,
  parameter int LINE_W = 25,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  in_row,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [LINE_W-1:0] line,
  output logic              line_valid,
  input  logic              line_ack,
  output logic [2:0]        row_idx,
  output logic [CNT_W-1:0]  line_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   a_q, a_d;
  logic [2:0]          r_q, r_d;
  logic [LINE_W-1:0]   o_q, o_d;
  logic                lv_q, lv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   a_wr;
  logic                o_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      a_q     <= '0;
      r_q     <= '0;
      o_q     <= '0;
      lv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      o_q     <= o_d;
      lv_q    <= lv_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    r_d      = r_q;
    o_d      = o_q;
    lv_d     = lv_q;
    cnt_d    = cnt_q;
    in_ready = (state_q == FILL);
    o_free   = !lv_q || line_ack;

    // Assembly register with the incoming row merged into slot r.
    a_wr = a_q;
    for (int i = 0; i < ROWS; i++) begin
      if (int'(r_q) == i) a_wr[i*ROW_W +: ROW_W] = in_row;
    end

    if (lv_q && line_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
      lv_d  = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (flush) begin
          r_d = '0;
          a_d = '0;
        end else if (in_valid) begin
          if (int'(r_q) == ROWS - 1) begin
            r_d = '0;
            if (o_free) begin
              o_d  = a_wr;
              lv_d = 1'b1;
            end else begin
              a_d     = a_wr;
              state_d = HOLD;
            end
          end else begin
            a_d = a_wr;
            r_d = r_q + 3'd1;
          end
        end
      end
      HOLD: begin
        // Transfer lands on the ack edge itself, so output never bubbles.
        if (o_free) begin
          o_d     = a_q;
          lv_d    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign line       = o_q;
  assign line_valid = lv_q;
  assign row_idx    = r_q;
  assign line_count = cnt_q;

endmodule

// File: tb/tb_line_packer.sv
// Self-checking bench for line_packer: a queue of expected lines is filled as
// rows are driven and drained whenever the bench acknowledges a valid line.
module tb_line_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  in_row = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [24:0] line;
  logic        line_valid;
  logic        line_ack = 1'b0;
  logic [2:0]  row_idx;
  logic [7:0]  line_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [24:0] exp_q[$];
  logic [24:0] cur_line = '0;
  int          cur_n = 0;
  logic [7:0]  exp_count = '0;
  logic [24:0] first_line;

  line_packer dut (
    .clk(clk), .rst(rst), .in_row(in_row), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .line(line), .line_valid(line_valid),
    .line_ack(line_ack), .row_idx(row_idx), .line_count(line_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Consumption happens at the next rising edge; inputs are stable between edges.
  always @(negedge clk) begin
    if (rst && line_valid && line_ack) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_line", 32'(line), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      exp_count = exp_count + 8'd1;
    end
  end

  task automatic beat(input logic [4:0] row, input logic ack);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    in_row = row;
    in_valid = 1'b1;
    line_ack = ack;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    line_ack = 1'b0;
    if (!rdy) begin
      check("beat_ready", 32'(rdy), 32'd1);
    end else begin
      cur_line[cur_n*5 +: 5] = row;
      cur_n++;
      if (cur_n == 5) begin
        exp_q.push_back(cur_line);
        cur_line = '0;
        cur_n = 0;
      end
    end
  endtask

  task automatic ack_once();
    line_ack = 1'b1;
    @(posedge clk);
    #1;
    line_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(line_valid), 32'd0);
    check("rst_line", 32'(line), 32'd0);
    check("rst_row_idx", 32'(row_idx), 32'd0);
    check("rst_count", 32'(line_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Basic single-line assembly
    beat(5'h01, 1'b0); beat(5'h02, 1'b0); beat(5'h04, 1'b0);
    beat(5'h08, 1'b0); beat(5'h10, 1'b0);
    check("t1_valid", 32'(line_valid), 32'd1);
    check("t1_line", 32'(line), 32'h1041041);
    check("t1_row_idx", 32'(row_idx), 32'd0);
    ack_once();
    check("t1_count", 32'(line_count), 32'(exp_count));
    check("t1_valid_after", 32'(line_valid), 32'd0);

    // Back-to-back lines without ack: second line parks in HOLD
    for (int i = 0; i < 10; i++) beat(5'(i + 3), 1'b0);
    check("t2_hold_ready", 32'(in_ready), 32'd0);
    first_line = exp_q[0];
    in_row = 5'h1B;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("t2_stall_ready", 32'(in_ready), 32'd0);
      check("t2_stall_row_idx", 32'(row_idx), 32'd0);
      check("t2_stall_line", 32'(line), 32'(first_line));
    end
    in_valid = 1'b0;
    ack_once();
    check("t2_line2", 32'(line), 32'(exp_q[0]));
    check("t2_valid", 32'(line_valid), 32'd1);
    check("t2_ready", 32'(in_ready), 32'd1);
    check("t2_count", 32'(line_count), 32'(exp_count));
    for (int i = 0; i < 5; i++) beat(5'(5'h11 + i), 1'b0);
    check("t2_hold2_ready", 32'(in_ready), 32'd0);
    ack_once();
    check("t2_line3", 32'(line), 32'(exp_q[0]));
    ack_once();
    check("t2_drained", 32'(line_valid), 32'd0);
    check("t2_count2", 32'(line_count), 32'(exp_count));

    // Ack on the same edge the next line completes: direct swap, no HOLD
    for (int i = 0; i < 5; i++) beat(5'(7 * i + 1), 1'b0);
    for (int i = 0; i < 4; i++) beat(5'(3 * i + 2), 1'b0);
    beat(5'h15, 1'b1);
    check("t3_valid", 32'(line_valid), 32'd1);
    check("t3_line", 32'(line), 32'(exp_q[0]));
    check("t3_ready", 32'(in_ready), 32'd1);
    check("t3_count", 32'(line_count), 32'(exp_count));
    ack_once();

    // Flush discards a partial line and the beat it coincides with
    beat(5'h0A, 1'b0); beat(5'h0B, 1'b0); beat(5'h0C, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_row = 5'h0D;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    cur_line = '0;
    cur_n = 0;
    check("t4_row_idx", 32'(row_idx), 32'd0);
    check("t4_valid", 32'(line_valid), 32'd0);
    for (int i = 0; i < 5; i++) beat(5'h1F, 1'b0);
    check("t4_line", 32'(line), 32'h1FFFFFF);
    ack_once();

    // Asynchronous reset mid-line with a pending line
    for (int i = 0; i < 7; i++) beat(5'(i + 9), 1'b0);
    check("t5_pre_valid", 32'(line_valid), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("t5_valid", 32'(line_valid), 32'd0);
    check("t5_line", 32'(line), 32'd0);
    check("t5_count", 32'(line_count), 32'd0);
    check("t5_row_idx", 32'(row_idx), 32'd0);
    exp_q.delete();
    cur_line = '0;
    cur_n = 0;
    exp_count = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ready", 32'(in_ready), 32'd1);

    // 256 acked lines wrap the counter
    for (int l = 0; l < 256; l++) begin
      for (int i = 0; i < 5; i++) beat(5'($urandom_range(0, 31)), 1'b0);
      ack_once();
    end
    check("t6_wrap", 32'(line_count), 32'd0);
    check("t6_count", 32'(line_count), 32'(exp_count));
    ack_once();
    check("t6_idle_ack", 32'(line_count), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
